hazard_scoreboard: RTL and testbench
====================================

Name: hazard_scoreboard

Overview:
- Parametrised successor to the IF/ID bubble-insertion logic.
- Replaces the fixed three-stage destination compare with a per-register pending-latency scoreboard.
- Sits beside the ID stage. Each instruction issued from ID records its destination and result latency. Later instructions' sources are checked against the outstanding counts.
- Drives the IF/ID hold and ID/EX bubble. Handles early consumers (beq/bne/jr compare in ID), forwardable consumers, WAW ordering, pipeline freeze and flush.

Parameters:
- NREG, 32: number of architectural registers; register 0 is hardwired zero.
- AW, 5: register address width; clog2(NREG).
- LW, 3: latency field width; the maximum latency is 2^LW-1.
- FWD_DIST, 1: a non-early consumer may proceed when the remaining count is <= FWD_DIST, because the bypass network covers it.
- PCW, 32: stall performance counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- id_valid  in  1  ID holds a real instruction.
- id_rs  in  AW  source 1 address.
- id_rs_en  in  1  source 1 is read.
- id_rs_early  in  1  source 1 is needed in ID (branch compare, jr).
- id_rt  in  AW  source 2 address.
- id_rt_en  in  1  source 2 is read.
- id_rt_early  in  1  source 2 is needed in ID.
- id_wr_en  in  1  the instruction writes a register.
- id_wr_addr  in  AW  destination (rd/rt/31, already muxed).
- id_wr_lat  in  LW  cycles from issue until the result is readable from the register file.
- freeze  in  1  global pipeline freeze (memory wait); all state holds.
- flush  in  1  kill the instruction in ID; it is not recorded.
- stall  out  1  hold IF/ID and PC, inject a bubble into ID/EX.
- nopIFID  out  1  equal to stall; name kept for top-level compatibility.
- pend_mask  out  NREG  bit i = (cnt[i] != 0).
- stall_cycles  out  PCW  saturating count of cycles with stall=1.

Behaviour:
- State:
  - cnt[1..NREG-1], each LW bits; cnt[0] is constant 0.
  - The stall_cycles register.
- Reset (rst=0, asynchronous):
  - All cnt=0 and stall_cycles=0.
  - Hence stall=0, nopIFID=0 and pend_mask=0 immediately. No further cycle is needed.
- Readiness of a source (combinational, from registered cnt):
  - Ready if en=0, or addr=0, or (early=1 and cnt[addr]=0), or (early=0 and cnt[addr]<=FWD_DIST).
- WAW check:
  - Blocked if id_wr_en and id_wr_addr!=0 and id_wr_lat < cnt[id_wr_addr].
  - A shorter-latency writer must not overtake an older pending write.
- stall:
  - stall = id_valid & ~flush & (~ready(rs) | ~ready(rt) | waw_block).
  - stall is purely combinational; there is no added latency.
  - freeze does not force stall; the caller gates the pipeline separately.
- accept = id_valid & ~flush & ~stall & ~freeze.
- Per clock edge:
  - freeze=1: all cnt hold; stall_cycles holds.
  - freeze=0, for each i>0:
    - if accept and id_wr_en and id_wr_addr==i and id_wr_lat!=0, then cnt[i] <= id_wr_lat;
    - else if cnt[i]!=0, then cnt[i] <= cnt[i]-1.
  - Issue takes priority over decrement on the same register.
- id_wr_lat=0 or id_wr_addr=0: nothing is recorded.
- The instruction in ID next cycle sees cnt=id_wr_lat. Example: lat=2, FWD_DIST=1, an early consumer immediately after stalls 2 cycles; a normal consumer stalls 1 cycle.
- stall_cycles: increments on each edge with stall=1 and freeze=0; saturates at all-ones, with no wrap.
- flush with stall conditions present: stall=0 and nothing is recorded; outstanding counts keep decrementing.
- Source equals destination of the same instruction: readiness uses the pre-issue cnt, so there is no self-stall.
- Reset asserted mid-stall: stall drops asynchronously. After release the scoreboard is empty.

Test Plan:
- Reset, then idle: pend_mask=0, stall=0, stall_cycles=0; hold 5 cycles with id_valid=0 and confirm nothing changes.
- Load-use:
  - Issue wr r8 lat=2.
  - Next instruction reads rs=r8, early=0: stall=1 for exactly 1 cycle, then accepted. stall_cycles=1. pend_mask bit8 clears 2 cycles after issue.
- Branch:
  - Issue wr r9 lat=3, then beq rs=r9 with early=1: stall for 3 cycles. nopIFID mirrors stall. stall_cycles=3.
- Zero register and disabled sources:
  - Issue wr r0 lat=3: pend_mask stays 0.
  - Read rt=r5 with rt_en=0 while cnt[5]=3: no stall.
- WAW:
  - Issue wr r4 lat=4, then wr r4 lat=1: stall until cnt[4]<=1 (3 cycles); then cnt[4] is reloaded to 1.
- Freeze, flush and reset:
  - With cnt[7]=2, hold freeze for 4 cycles: cnt[7] stays 2 and stall_cycles holds.
  - Assert flush on a stalling instruction: stall=0 and nothing is recorded.
  - Drop rst mid-stall: outputs clear asynchronously, before the next edge.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// Per-register pending-latency scoreboard beside the ID stage: tracks how many
// cycles remain until each destination is readable and stalls dependent issue.
module hazard_scoreboard #(
    parameter int NREG     = 32,
    parameter int AW       = 5,
    parameter int LW       = 3,
    parameter int FWD_DIST = 1,
    parameter int PCW      = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            id_valid,
    input  logic [AW-1:0]   id_rs,
    input  logic            id_rs_en,
    input  logic            id_rs_early,
    input  logic [AW-1:0]   id_rt,
    input  logic            id_rt_en,
    input  logic            id_rt_early,
    input  logic            id_wr_en,
    input  logic [AW-1:0]   id_wr_addr,
    input  logic [LW-1:0]   id_wr_lat,
    input  logic            freeze,
    input  logic            flush,
    output logic            stall,
    output logic            nopIFID,
    output logic [NREG-1:0] pend_mask,
    output logic [PCW-1:0]  stall_cycles
);

    logic [LW-1:0] cnt_reg [NREG];
    logic [LW-1:0] rs_cnt;
    logic [LW-1:0] rt_cnt;
    logic [LW-1:0] wr_cnt;
    logic          rs_ready;
    logic          rt_ready;
    logic          waw_block;
    logic          accept;
    logic          load_en;

    assign rs_cnt = cnt_reg[id_rs];
    assign rt_cnt = cnt_reg[id_rt];
    assign wr_cnt = cnt_reg[id_wr_addr];

    // Early consumers read the register file in ID, so they need a fully
    // retired write; others can pick the value off the bypass network.
    always_comb begin
        rs_ready = !id_rs_en || (id_rs == '0) ||
                   (id_rs_early ? (rs_cnt == '0) : (int'(rs_cnt) <= FWD_DIST));
        rt_ready = !id_rt_en || (id_rt == '0) ||
                   (id_rt_early ? (rt_cnt == '0) : (int'(rt_cnt) <= FWD_DIST));
        waw_block = id_wr_en && (id_wr_addr != '0) && (id_wr_lat < wr_cnt);
        stall     = id_valid && !flush && (!rs_ready || !rt_ready || waw_block);
        accept    = id_valid && !flush && !stall && !freeze;
        load_en   = accept && id_wr_en && (id_wr_lat != '0);
    end

    assign nopIFID = stall;

    // Entry 0 is cleared by reset and never written afterwards.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) begin
                cnt_reg[i] <= '0;
            end
        end else if (!freeze) begin
            for (int i = 1; i < NREG; i++) begin
                if (load_en && (id_wr_addr == AW'(i))) begin
                    cnt_reg[i] <= id_wr_lat;
                end else if (cnt_reg[i] != '0) begin
                    cnt_reg[i] <= cnt_reg[i] - LW'(1);
                end
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NREG; gi++) begin : g_pend
            assign pend_mask[gi] = (cnt_reg[gi] != '0);
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cycles <= '0;
        end else if (!freeze && stall && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + PCW'(1);
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: per-cycle vector table with hand-derived
// expectations queued at drive time and compared mid-cycle.
module tb_hazard_scoreboard;

    localparam int PCW = 4;

    logic        clk;
    logic        rst;
    logic        id_valid;
    logic [4:0]  id_rs;
    logic        id_rs_en;
    logic        id_rs_early;
    logic [4:0]  id_rt;
    logic        id_rt_en;
    logic        id_rt_early;
    logic        id_wr_en;
    logic [4:0]  id_wr_addr;
    logic [2:0]  id_wr_lat;
    logic        freeze;
    logic        flush;
    logic        stall;
    logic        nopIFID;
    logic [31:0] pend_mask;
    logic [PCW-1:0] stall_cycles;

    hazard_scoreboard #(.NREG(32), .AW(5), .LW(3), .FWD_DIST(1), .PCW(PCW)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_rs(id_rs), .id_rs_en(id_rs_en), .id_rs_early(id_rs_early),
        .id_rt(id_rt), .id_rt_en(id_rt_en), .id_rt_early(id_rt_early),
        .id_wr_en(id_wr_en), .id_wr_addr(id_wr_addr), .id_wr_lat(id_wr_lat),
        .freeze(freeze), .flush(flush), .stall(stall), .nopIFID(nopIFID),
        .pend_mask(pend_mask), .stall_cycles(stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic [4:0]  rs;
        logic        rs_en;
        logic        rs_early;
        logic [4:0]  rt;
        logic        rt_en;
        logic        rt_early;
        logic        wr_en;
        logic [4:0]  wa;
        logic [2:0]  wl;
        logic        frz;
        logic        fl;
        logic        es;
        logic [31:0] epm;
        logic [3:0]  esc;
    } vec_t;

    typedef struct {
        int          idx;
        logic        es;
        logic [31:0] epm;
        logic [3:0]  esc;
    } exp_t;

    vec_t tbl[$];
    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;

    function automatic vec_t mk(logic v, logic [4:0] rs, logic rse, logic rsy,
                                logic [4:0] rt, logic rte, logic rty,
                                logic we, logic [4:0] wa, logic [2:0] wl,
                                logic frz, logic fl,
                                logic es, logic [31:0] epm, logic [3:0] esc);
        vec_t r;
        r.valid = v;  r.rs = rs; r.rs_en = rse; r.rs_early = rsy;
        r.rt = rt;    r.rt_en = rte; r.rt_early = rty;
        r.wr_en = we; r.wa = wa; r.wl = wl; r.frz = frz; r.fl = fl;
        r.es = es;    r.epm = epm; r.esc = esc;
        return r;
    endfunction

    function automatic vec_t idle(logic [31:0] epm, logic [3:0] esc);
        return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, epm, esc);
    endfunction

    function automatic vec_t wr(logic [4:0] wa, logic [2:0] wl, logic [31:0] epm, logic [3:0] esc);
        return mk(1, 0, 0, 0, 0, 0, 0, 1, wa, wl, 0, 0, 0, epm, esc);
    endfunction

    task automatic chk(string nm, int idx, logic [31:0] act, logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s row=%0d got=%h want=%h", nm, idx, act, req);
        end
    endtask

    task automatic drive(vec_t r);
        id_valid = r.valid; id_rs = r.rs; id_rs_en = r.rs_en; id_rs_early = r.rs_early;
        id_rt = r.rt; id_rt_en = r.rt_en; id_rt_early = r.rt_early;
        id_wr_en = r.wr_en; id_wr_addr = r.wa; id_wr_lat = r.wl;
        freeze = r.frz; flush = r.fl;
    endtask

    task automatic check_front();
        exp_t e;
        e = exp_q.pop_front();
        chk("stall", e.idx, 32'(stall), 32'(e.es));
        chk("nopIFID", e.idx, 32'(nopIFID), 32'(e.es));
        chk("pend_mask", e.idx, pend_mask, e.epm);
        chk("stall_cycles", e.idx, 32'(stall_cycles), 32'(e.esc));
        $display("txn %0d: stall=%0b pend=%h cyc=%0d", e.idx, stall, pend_mask, stall_cycles);
    endtask

    task automatic run_row(vec_t r, int idx);
        exp_t e;
        @(posedge clk);
        #1;
        drive(r);
        e.idx = idx; e.es = r.es; e.epm = r.epm; e.esc = r.esc;
        exp_q.push_back(e);
        @(negedge clk);
        check_front();
    endtask

    initial begin
        // idle after reset
        for (int i = 0; i < 5; i++) tbl.push_back(idle(0, 0));
        // load-use on r8, lat 2
        tbl.push_back(wr(8, 2, 0, 0));
        tbl.push_back(mk(1, 8, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h100, 0));
        tbl.push_back(mk(1, 8, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h100, 1));
        // branch on r9, lat 3
        tbl.push_back(wr(9, 3, 0, 1));
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk(1, 9, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h200, 4'(1 + i)));
        tbl.push_back(mk(1, 9, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4));
        // r0 write ignored; disabled rt source
        tbl.push_back(wr(0, 3, 0, 4));
        tbl.push_back(wr(5, 3, 0, 4));
        tbl.push_back(mk(1, 0, 0, 0, 5, 0, 1, 0, 0, 0, 0, 0, 0, 32'h20, 4));
        tbl.push_back(idle(32'h20, 4));
        tbl.push_back(idle(32'h20, 4));
        // WAW on r4: lat 4 then lat 1
        tbl.push_back(wr(4, 4, 0, 4));
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 4, 1, 0, 0, 1, 32'h10, 4'(4 + i)));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 4, 1, 0, 0, 0, 32'h10, 7));
        tbl.push_back(idle(32'h10, 7));
        tbl.push_back(idle(0, 7));
        // freeze with r7 pending
        tbl.push_back(wr(7, 2, 0, 7));
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk(1, 7, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 32'h80, 7));
        tbl.push_back(mk(1, 7, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h80, 7));
        tbl.push_back(mk(1, 7, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h80, 8));
        // flush of a stalling writer
        tbl.push_back(wr(10, 3, 0, 8));
        tbl.push_back(mk(1, 10, 1, 1, 0, 0, 0, 1, 11, 2, 0, 1, 0, 32'h400, 8));
        tbl.push_back(idle(32'h400, 8));
        tbl.push_back(idle(32'h400, 8));
        tbl.push_back(idle(0, 8));
        // source == destination: no self-stall
        tbl.push_back(mk(1, 12, 1, 1, 0, 0, 0, 1, 12, 2, 0, 0, 0, 0, 8));
        tbl.push_back(idle(32'h1000, 8));
        tbl.push_back(idle(32'h1000, 8));
        // long early stall on r13 drives the counter into saturation
        tbl.push_back(wr(13, 7, 0, 8));
        for (int i = 0; i < 7; i++)
            tbl.push_back(mk(1, 0, 0, 0, 13, 1, 1, 0, 0, 0, 0, 0, 1, 32'h2000, 4'(8 + i)));
        tbl.push_back(mk(1, 0, 0, 0, 13, 1, 1, 0, 0, 0, 0, 0, 0, 0, 15));
        tbl.push_back(wr(14, 3, 0, 15));
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk(1, 14, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h4000, 15));
        tbl.push_back(mk(1, 14, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 15));

        rst = 1'b0;
        drive(idle(0, 0));
        #2;
        chk("reset_stall", -1, 32'(stall), 0);
        chk("reset_pend", -1, pend_mask, 0);
        chk("reset_cycles", -1, 32'(stall_cycles), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < tbl.size(); i++) run_row(tbl[i], i);

        // asynchronous reset in the middle of a stall
        run_row(wr(6, 5, 0, 15), 100);
        run_row(mk(1, 6, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h40, 15), 101);
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk("midrst_stall", 102, 32'(stall), 0);
        chk("midrst_nop", 102, 32'(nopIFID), 0);
        chk("midrst_pend", 102, pend_mask, 0);
        chk("midrst_cycles", 102, 32'(stall_cycles), 0);
        @(negedge clk);
        rst = 1'b1;
        run_row(mk(1, 6, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 103);
        run_row(idle(0, 0), 104);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
